alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares one execute-stage ALU between two requesters: port 0 is the main pipeline, port 1 is the branch/address-generation path.
- Round-robin arbitration with valid/ready handshakes on both request ports and on the single response port.
- The ALU evaluation is done inside the block on the granted request's operands; the result is registered into a single-entry output stage.
- The block sits between issue logic and writeback/branch-resolve and replaces per-requester ALU copies.

Parameters:
- WIDTH, 32, operand/result width in bits.
- TAG_W, 4, width of the opaque tag carried from request to response.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  port 0 request valid.
- req0_ready  output  1  port 0 request accepted this cycle.
- req0_a  input  WIDTH  port 0 operand A.
- req0_b  input  WIDTH  port 0 operand B.
- req0_ctrl  input  4  port 0 ALU control code.
- req0_tag  input  TAG_W  port 0 tag.
- req1_valid, req1_ready, req1_a, req1_b, req1_ctrl, req1_tag: same directions, widths and meanings as port 0, for port 1.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accepts response.
- rsp_result  output  WIDTH  ALU result.
- rsp_zero  output  1  result equals 0.
- rsp_id  output  1  requester that produced this response (0/1).
- rsp_tag  output  TAG_W  tag of that request.
- rsp_illegal  output  1  ctrl code was unsupported.

Behaviour:
- Reset (async, rst_n=0): rsp_valid=0; rsp_result=0; rsp_zero=0; rsp_id=0; rsp_tag=0; rsp_illegal=0; last_grant=1.
  - Any held, unconsumed response is discarded.
  - Ready outputs are 0 while rst_n=0.
- Output stage states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- can_accept = EMPTY, or (FULL and rsp_ready=1).
  - Accepting in the same cycle the held response drains gives 1 response/cycle throughput.
- Grant rules:
  - Only one valid: that port is granted.
  - Both valid: the port != last_grant is granted. After reset, port 0 wins the first tie.
  - reqN_ready = grant_N & can_accept. Ready may depend on valid; requesters must not make valid depend on ready.
- Handshake:
  - A transfer occurs when reqN_valid & reqN_ready.
  - On a transfer, the output register loads next edge and the state becomes FULL; last_grant updates to N.
  - last_grant updates only on an actual transfer, not on a grant that is stalled.
- FULL with rsp_ready=0 and no new transfer: hold all rsp_* stable. Request ready stays 0.
- FULL with rsp_ready=1 and no new transfer: state returns to EMPTY.
- Latency: exactly 1 cycle from accepting edge to rsp_valid.
- ALU codes:
  - 4'b0010: add, modulo 2^WIDTH.
  - 4'b0110: subtract A-B, modulo 2^WIDTH.
  - 4'b0000: bitwise AND.
  - 4'b0001: bitwise OR.
  - 4'b0111: signed set-less-than; result 1 if $signed(A)<$signed(B), else 0.
  - Any other code: result 0, rsp_illegal=1, rsp_zero=1. The response is still produced and consumes a grant.
- rsp_zero = (rsp_result == 0), registered together with the result.
- Input changes while not granted are ignored. Operands are sampled only on the transfer edge.

Optional Feature:
- ALU_SHARE_ARBITER_OVF_EN: adds output rsp_overflow (1 bit, reset 0).
  - Registered with the result.
  - Set for add when A and B have equal signs and the result sign differs.
  - Set for sub when A and B have differing signs and the result sign differs from A.
  - 0 for all other codes.
- Without the macro, the port does not exist and no overflow logic is built.

Test Plan:
- Reset then req0 valid, a=5, b=7, ctrl=0010, tag=3, rsp_ready=1 -> req0_ready=1 same cycle; next cycle rsp_valid=1, result=12, zero=0, id=0, tag=3.
- Both ports valid continuously, rsp_ready=1, 6 cycles -> grants alternate 0,1,0,1,0,1; one response per cycle; rsp_id sequence matches.
- rsp_ready=0 held 3 cycles after a response -> rsp_* stable; req0_ready=req1_ready=0. Release rsp_ready -> pending request accepted the same cycle.
- req1 a=0x7FFFFFFF, b=1, ctrl=0010 -> result 0x80000000 (wraps). With OVF_EN, rsp_overflow=1.
- ctrl=0111, a=0xFFFFFFFF, b=1 -> result 1. ctrl=0110, a=b=9 -> result 0, zero=1. ctrl=1111 -> result 0, illegal=1.
- Assert rst_n=0 while FULL with rsp_ready=0 -> rsp_valid drops immediately. After release, a tie is granted to port 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two requesters with a single registered response stage.
// Optional overflow output is built when ALU_SHARE_ARBITER_OVF_EN is defined.
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_ctrl,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_ctrl,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_illegal
`ifdef ALU_SHARE_ARBITER_OVF_EN
  ,
  output logic             rsp_overflow
`endif
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               id_q, id_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               illegal_q, illegal_d;
  logic               last_grant_q, last_grant_d;

  logic               can_accept, grant0, grant1, xfer0, xfer1;
  logic [WIDTH-1:0]   op_a, op_b, alu_res;
  logic [3:0]         op_ctrl;
  logic               alu_illegal;

`ifdef ALU_SHARE_ARBITER_OVF_EN
  logic ovf_q, ovf_d, alu_ovf;
`endif

  // Port that did not win last time takes a tie.
  assign can_accept = (state_q == StEmpty) || rsp_ready;
  assign grant0     = req0_valid && (!req1_valid || last_grant_q);
  assign grant1     = req1_valid && (!req0_valid || !last_grant_q);
  assign req0_ready = grant0 && can_accept && rst_n;
  assign req1_ready = grant1 && can_accept && rst_n;
  assign xfer0      = req0_valid && req0_ready;
  assign xfer1      = req1_valid && req1_ready;

  assign op_a    = xfer1 ? req1_a    : req0_a;
  assign op_b    = xfer1 ? req1_b    : req0_b;
  assign op_ctrl = xfer1 ? req1_ctrl : req0_ctrl;

  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    unique case (op_ctrl)
      4'b0010: alu_res = op_a + op_b;
      4'b0110: alu_res = op_a - op_b;
      4'b0000: alu_res = op_a & op_b;
      4'b0001: alu_res = op_a | op_b;
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: alu_illegal = 1'b1;
    endcase
  end

`ifdef ALU_SHARE_ARBITER_OVF_EN
  always_comb begin
    alu_ovf = 1'b0;
    if (op_ctrl == 4'b0010) begin
      alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
    end else if (op_ctrl == 4'b0110) begin
      alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    result_d     = result_q;
    zero_d       = zero_q;
    id_d         = id_q;
    tag_d        = tag_q;
    illegal_d    = illegal_q;
    last_grant_d = last_grant_q;
`ifdef ALU_SHARE_ARBITER_OVF_EN
    ovf_d        = ovf_q;
`endif
    if (xfer0 || xfer1) begin
      state_d      = StFull;
      result_d     = alu_res;
      zero_d       = (alu_res == '0);
      id_d         = xfer1;
      tag_d        = xfer1 ? req1_tag : req0_tag;
      illegal_d    = alu_illegal;
      last_grant_d = xfer1;
`ifdef ALU_SHARE_ARBITER_OVF_EN
      ovf_d        = alu_ovf;
`endif
    end else if ((state_q == StFull) && rsp_ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StEmpty;
      result_q     <= '0;
      zero_q       <= 1'b0;
      id_q         <= 1'b0;
      tag_q        <= '0;
      illegal_q    <= 1'b0;
      last_grant_q <= 1'b1;
`ifdef ALU_SHARE_ARBITER_OVF_EN
      ovf_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      id_q         <= id_d;
      tag_q        <= tag_d;
      illegal_q    <= illegal_d;
      last_grant_q <= last_grant_d;
`ifdef ALU_SHARE_ARBITER_OVF_EN
      ovf_q        <= ovf_d;
`endif
    end
  end

  assign rsp_valid   = (state_q == StFull);
  assign rsp_result  = result_q;
  assign rsp_zero    = zero_q;
  assign rsp_id      = id_q;
  assign rsp_tag     = tag_q;
  assign rsp_illegal = illegal_q;
`ifdef ALU_SHARE_ARBITER_OVF_EN
  assign rsp_overflow = ovf_q;
`endif

endmodule
